// File: rtl/sq_wave_meter.sv
// sq_wave_meter: measures the high and low durations of a same-clock square wave
// and reports each complete period as raw cycle counts plus whole UNIT counts.
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   en                measurement enable; low aborts the current period and re-arms
//   sq_in             waveform under test (already in the clk domain)
//   hi_len, lo_len    high/low duration of the last period in cycles (saturating)
//   hi_units, lo_units floor(len/UNIT), saturating at 2^Q_W-1
//   hi_exact, lo_exact len is a whole multiple of UNIT
//   ovf               a cycle counter saturated during the reported period
//   valid             one-cycle pulse when new period results are presented
//   locked            at least one valid since reset / en rising
module sq_wave_meter #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned UNIT  = 5,
  parameter int unsigned Q_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sq_in,
  output logic [CNT_W-1:0] hi_len,
  output logic [CNT_W-1:0] lo_len,
  output logic [Q_W-1:0]   hi_units,
  output logic [Q_W-1:0]   lo_units,
  output logic             hi_exact,
  output logic             lo_exact,
  output logic             ovf,
  output logic             valid,
  output logic             locked
);

  localparam int unsigned REM_W = (UNIT > 1) ? $clog2(UNIT) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [Q_W-1:0]   Q_MAX     = {Q_W{1'b1}};
  localparam logic [REM_W-1:0] REM_LAST  = REM_W'(UNIT - 1);
  // First counted cycle of a phase, already folded into rem/quotient
  localparam logic [REM_W-1:0] REM_START = (UNIT == 1) ? REM_W'(0) : REM_W'(1);
  localparam logic [Q_W-1:0]   Q_START   = (UNIT == 1) ? Q_W'(1) : Q_W'(0);

  typedef enum logic [1:0] {
    S_SYNC,
    S_ARMED,
    S_HIGH,
    S_LOW
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d, lo_cnt_q, lo_cnt_d;
  logic [REM_W-1:0] hi_rem_q, hi_rem_d, lo_rem_q, lo_rem_d;
  logic [Q_W-1:0]   hi_quo_q, hi_quo_d, lo_quo_q, lo_quo_d;
  logic             hi_ovf_q, hi_ovf_d, lo_ovf_q, lo_ovf_d;
  logic [CNT_W-1:0] hi_len_q, hi_len_d, lo_len_q, lo_len_d;
  logic [Q_W-1:0]   hi_units_q, hi_units_d, lo_units_q, lo_units_d;
  logic             hi_exact_q, hi_exact_d, lo_exact_q, lo_exact_d;
  logic             ovf_q, ovf_d, valid_q, valid_d, locked_q, locked_d;

  // Remainder advance: wraps at UNIT-1
  function automatic logic [REM_W-1:0] rem_step(input logic [REM_W-1:0] r);
    return (r == REM_LAST) ? REM_W'(0) : r + REM_W'(1);
  endfunction

  // Quotient advance on remainder wrap, saturating
  function automatic logic [Q_W-1:0] quo_step(input logic [REM_W-1:0] r,
                                              input logic [Q_W-1:0]   q);
    return ((r == REM_LAST) && (q != Q_MAX)) ? q + Q_W'(1) : q;
  endfunction

  // Next-state, phase counters and result latching
  always_comb begin
    state_d    = state_q;
    hi_cnt_d   = hi_cnt_q;
    lo_cnt_d   = lo_cnt_q;
    hi_rem_d   = hi_rem_q;
    lo_rem_d   = lo_rem_q;
    hi_quo_d   = hi_quo_q;
    lo_quo_d   = lo_quo_q;
    hi_ovf_d   = hi_ovf_q;
    lo_ovf_d   = lo_ovf_q;
    hi_len_d   = hi_len_q;
    lo_len_d   = lo_len_q;
    hi_units_d = hi_units_q;
    lo_units_d = lo_units_q;
    hi_exact_d = hi_exact_q;
    lo_exact_d = lo_exact_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;
    locked_d   = locked_q;

    unique case (state_q)
      S_SYNC: begin
        // Wait for low so a partial high phase is never measured
        if (!sq_in) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (sq_in) begin
          state_d  = S_HIGH;
          hi_cnt_d = CNT_W'(1);
          hi_rem_d = REM_START;
          hi_quo_d = Q_START;
          hi_ovf_d = 1'b0;
          lo_ovf_d = 1'b0;
        end
      end
      S_HIGH: begin
        if (sq_in) begin
          // A saturated counter holds and stops feeding the unit tracker
          if (hi_cnt_q == CNT_MAX) begin
            hi_ovf_d = 1'b1;
          end else begin
            hi_cnt_d = hi_cnt_q + CNT_W'(1);
            hi_rem_d = rem_step(hi_rem_q);
            hi_quo_d = quo_step(hi_rem_q, hi_quo_q);
          end
        end else begin
          state_d  = S_LOW;
          lo_cnt_d = CNT_W'(1);
          lo_rem_d = REM_START;
          lo_quo_d = Q_START;
        end
      end
      S_LOW: begin
        if (!sq_in) begin
          if (lo_cnt_q == CNT_MAX) begin
            lo_ovf_d = 1'b1;
          end else begin
            lo_cnt_d = lo_cnt_q + CNT_W'(1);
            lo_rem_d = rem_step(lo_rem_q);
            lo_quo_d = quo_step(lo_rem_q, lo_quo_q);
          end
        end else begin
          // Period complete: publish, then start the next high phase
          hi_len_d   = hi_cnt_q;
          lo_len_d   = lo_cnt_q;
          hi_units_d = hi_quo_q;
          lo_units_d = lo_quo_q;
          hi_exact_d = (hi_rem_q == REM_W'(0));
          lo_exact_d = (lo_rem_q == REM_W'(0));
          ovf_d      = hi_ovf_q | lo_ovf_q;
          valid_d    = 1'b1;
          locked_d   = 1'b1;
          state_d    = S_HIGH;
          hi_cnt_d   = CNT_W'(1);
          hi_rem_d   = REM_START;
          hi_quo_d   = Q_START;
          hi_ovf_d   = 1'b0;
          lo_ovf_d   = 1'b0;
        end
      end
      default: state_d = S_SYNC;
    endcase

    // Disable aborts the measurement; published results are kept
    if (!en) begin
      state_d  = S_SYNC;
      hi_cnt_d = '0;
      lo_cnt_d = '0;
      hi_rem_d = '0;
      lo_rem_d = '0;
      hi_quo_d = '0;
      lo_quo_d = '0;
      hi_ovf_d = 1'b0;
      lo_ovf_d = 1'b0;
      valid_d  = 1'b0;
      locked_d = 1'b0;
    end
  end

  // State and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_SYNC;
      hi_cnt_q   <= '0;
      lo_cnt_q   <= '0;
      hi_rem_q   <= '0;
      lo_rem_q   <= '0;
      hi_quo_q   <= '0;
      lo_quo_q   <= '0;
      hi_ovf_q   <= 1'b0;
      lo_ovf_q   <= 1'b0;
      hi_len_q   <= '0;
      lo_len_q   <= '0;
      hi_units_q <= '0;
      lo_units_q <= '0;
      hi_exact_q <= 1'b0;
      lo_exact_q <= 1'b0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_cnt_q   <= hi_cnt_d;
      lo_cnt_q   <= lo_cnt_d;
      hi_rem_q   <= hi_rem_d;
      lo_rem_q   <= lo_rem_d;
      hi_quo_q   <= hi_quo_d;
      lo_quo_q   <= lo_quo_d;
      hi_ovf_q   <= hi_ovf_d;
      lo_ovf_q   <= lo_ovf_d;
      hi_len_q   <= hi_len_d;
      lo_len_q   <= lo_len_d;
      hi_units_q <= hi_units_d;
      lo_units_q <= lo_units_d;
      hi_exact_q <= hi_exact_d;
      lo_exact_q <= lo_exact_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
    end
  end

  assign hi_len   = hi_len_q;
  assign lo_len   = lo_len_q;
  assign hi_units = hi_units_q;
  assign lo_units = lo_units_q;
  assign hi_exact = hi_exact_q;
  assign lo_exact = lo_exact_q;
  assign ovf      = ovf_q;
  assign valid    = valid_q;
  assign locked   = locked_q;

endmodule

// File: tb/tb_sq_wave_meter.sv
// Directed bench for sq_wave_meter (CNT_W=8, UNIT=5, Q_W=4).
module tb_sq_wave_meter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       sq_in;
  logic [7:0] hi_len, lo_len;
  logic [3:0] hi_units, lo_units;
  logic       hi_exact, lo_exact, ovf, valid, locked;

  int nvec;
  int nerr;
  int cyc;
  int nvalid;
  int last_vcyc;
  int gap_min;
  int gap_max;

  sq_wave_meter #(.CNT_W(8), .UNIT(5), .Q_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sq_in    (sq_in),
    .hi_len   (hi_len),
    .lo_len   (lo_len),
    .hi_units (hi_units),
    .lo_units (lo_units),
    .hi_exact (hi_exact),
    .lo_exact (lo_exact),
    .ovf      (ovf),
    .valid    (valid),
    .locked   (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_stats();
    nvalid    = 0;
    last_vcyc = -1;
    gap_min   = 32'h7fffffff;
    gap_max   = 0;
  endtask

  // One clock with sq_in=v; outputs sampled 1ns after the edge
  task automatic step(input logic v);
    sq_in = v;
    @(posedge clk);
    #1;
    cyc++;
    if (valid === 1'b1) begin
      if (last_vcyc >= 0) begin
        if (cyc - last_vcyc < gap_min) gap_min = cyc - last_vcyc;
        if (cyc - last_vcyc > gap_max) gap_max = cyc - last_vcyc;
      end
      last_vcyc = cyc;
      nvalid++;
    end
  endtask

  task automatic phase(input logic v, input int n);
    repeat (n) step(v);
  endtask

  task automatic do_reset(input logic v);
    rst = 1'b1;
    en  = 1'b1;
    phase(v, 2);
    rst = 1'b0;
    clear_stats();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    phase(1'b1, 2);
    nvec++; if (hi_len !== 8'd0)   begin nerr++; $display("FAIL rst_hi_len got %0d exp 0", hi_len); end
    nvec++; if (lo_len !== 8'd0)   begin nerr++; $display("FAIL rst_lo_len got %0d exp 0", lo_len); end
    nvec++; if (hi_units !== 4'd0) begin nerr++; $display("FAIL rst_hi_units got %0d exp 0", hi_units); end
    nvec++; if (lo_units !== 4'd0) begin nerr++; $display("FAIL rst_lo_units got %0d exp 0", lo_units); end
    nvec++; if (hi_exact !== 1'b0) begin nerr++; $display("FAIL rst_hi_exact got %b exp 0", hi_exact); end
    nvec++; if (lo_exact !== 1'b0) begin nerr++; $display("FAIL rst_lo_exact got %b exp 0", lo_exact); end
    nvec++; if (ovf !== 1'b0)      begin nerr++; $display("FAIL rst_ovf got %b exp 0", ovf); end
    nvec++; if (valid !== 1'b0)    begin nerr++; $display("FAIL rst_valid got %b exp 0", valid); end
    nvec++; if (locked !== 1'b0)   begin nerr++; $display("FAIL rst_locked got %b exp 0", locked); end
  endtask

  // m=3 n=2 waveform: 15 high, 10 low, period 25
  task automatic test_nominal();
    do_reset(1'b0);
    phase(1'b0, 3);
    for (int p = 0; p < 3; p++) begin
      phase(1'b1, 15);
      phase(1'b0, 10);
    end
    step(1'b1);
    nvec++; if (nvalid !== 3)      begin nerr++; $display("FAIL t1_nvalid got %0d exp 3", nvalid); end
    nvec++; if (gap_min !== 25)    begin nerr++; $display("FAIL t1_gap_min got %0d exp 25", gap_min); end
    nvec++; if (gap_max !== 25)    begin nerr++; $display("FAIL t1_gap_max got %0d exp 25", gap_max); end
    nvec++; if (valid !== 1'b1)    begin nerr++; $display("FAIL t1_valid_now got %b exp 1", valid); end
    nvec++; if (hi_len !== 8'd15)  begin nerr++; $display("FAIL t1_hi_len got %0d exp 15", hi_len); end
    nvec++; if (lo_len !== 8'd10)  begin nerr++; $display("FAIL t1_lo_len got %0d exp 10", lo_len); end
    nvec++; if (hi_units !== 4'd3) begin nerr++; $display("FAIL t1_hi_units got %0d exp 3", hi_units); end
    nvec++; if (lo_units !== 4'd2) begin nerr++; $display("FAIL t1_lo_units got %0d exp 2", lo_units); end
    nvec++; if (hi_exact !== 1'b1) begin nerr++; $display("FAIL t1_hi_exact got %b exp 1", hi_exact); end
    nvec++; if (lo_exact !== 1'b1) begin nerr++; $display("FAIL t1_lo_exact got %b exp 1", lo_exact); end
    nvec++; if (ovf !== 1'b0)      begin nerr++; $display("FAIL t1_ovf got %b exp 0", ovf); end
    nvec++; if (locked !== 1'b1)   begin nerr++; $display("FAIL t1_locked got %b exp 1", locked); end
    step(1'b1);
    nvec++; if (valid !== 1'b0)    begin nerr++; $display("FAIL t1_valid_pulse got %b exp 0", valid); end
    nvec++; if (hi_len !== 8'd15)  begin nerr++; $display("FAIL t1_hold_hi_len got %0d exp 15", hi_len); end
  endtask

  // Continues the high phase begun in test_nominal (2 cycles so far): high 7, low 12
  task automatic test_non_exact();
    phase(1'b1, 5);
    clear_stats();
    phase(1'b0, 12);
    nvec++; if (nvalid !== 0)      begin nerr++; $display("FAIL t2_early_valid got %0d exp 0", nvalid); end
    step(1'b1);
    nvec++; if (valid !== 1'b1)    begin nerr++; $display("FAIL t2_valid got %b exp 1", valid); end
    nvec++; if (hi_len !== 8'd7)   begin nerr++; $display("FAIL t2_hi_len got %0d exp 7", hi_len); end
    nvec++; if (lo_len !== 8'd12)  begin nerr++; $display("FAIL t2_lo_len got %0d exp 12", lo_len); end
    nvec++; if (hi_units !== 4'd1) begin nerr++; $display("FAIL t2_hi_units got %0d exp 1", hi_units); end
    nvec++; if (lo_units !== 4'd2) begin nerr++; $display("FAIL t2_lo_units got %0d exp 2", lo_units); end
    nvec++; if (hi_exact !== 1'b0) begin nerr++; $display("FAIL t2_hi_exact got %b exp 0", hi_exact); end
    nvec++; if (lo_exact !== 1'b0) begin nerr++; $display("FAIL t2_lo_exact got %b exp 0", lo_exact); end
  endtask

  // Reset released mid-high: partial high and partial low are both discarded
  task automatic test_reset_mid_phase();
    do_reset(1'b1);
    nvec++; if (hi_len !== 8'd0)   begin nerr++; $display("FAIL t3_rst_hi_len got %0d exp 0", hi_len); end
    nvec++; if (locked !== 1'b0)   begin nerr++; $display("FAIL t3_rst_locked got %b exp 0", locked); end
    phase(1'b1, 5);
    phase(1'b0, 4);
    phase(1'b1, 8);
    phase(1'b0, 6);
    nvec++; if (nvalid !== 0)      begin nerr++; $display("FAIL t3_partial_valid got %0d exp 0", nvalid); end
    step(1'b1);
    nvec++; if (nvalid !== 1)      begin nerr++; $display("FAIL t3_nvalid got %0d exp 1", nvalid); end
    nvec++; if (hi_len !== 8'd8)   begin nerr++; $display("FAIL t3_hi_len got %0d exp 8", hi_len); end
    nvec++; if (lo_len !== 8'd6)   begin nerr++; $display("FAIL t3_lo_len got %0d exp 6", lo_len); end
    nvec++; if (hi_units !== 4'd1) begin nerr++; $display("FAIL t3_hi_units got %0d exp 1", hi_units); end
    nvec++; if (lo_units !== 4'd1) begin nerr++; $display("FAIL t3_lo_units got %0d exp 1", lo_units); end
  endtask

  // 300-cycle high saturates; the following period must report ovf=0 again
  task automatic test_saturation();
    do_reset(1'b0);
    phase(1'b0, 2);
    phase(1'b1, 300);
    phase(1'b0, 4);
    step(1'b1);
    nvec++; if (nvalid !== 1)       begin nerr++; $display("FAIL t4_nvalid got %0d exp 1", nvalid); end
    nvec++; if (hi_len !== 8'd255)  begin nerr++; $display("FAIL t4_hi_len got %0d exp 255", hi_len); end
    nvec++; if (ovf !== 1'b1)       begin nerr++; $display("FAIL t4_ovf got %b exp 1", ovf); end
    nvec++; if (hi_units !== 4'd15) begin nerr++; $display("FAIL t4_hi_units got %0d exp 15", hi_units); end
    nvec++; if (hi_exact !== 1'b1)  begin nerr++; $display("FAIL t4_hi_exact got %b exp 1", hi_exact); end
    nvec++; if (lo_len !== 8'd4)    begin nerr++; $display("FAIL t4_lo_len got %0d exp 4", lo_len); end
    nvec++; if (lo_units !== 4'd0)  begin nerr++; $display("FAIL t4_lo_units got %0d exp 0", lo_units); end
    nvec++; if (lo_exact !== 1'b0)  begin nerr++; $display("FAIL t4_lo_exact got %b exp 0", lo_exact); end
    phase(1'b1, 4);
    phase(1'b0, 5);
    step(1'b1);
    nvec++; if (nvalid !== 2)       begin nerr++; $display("FAIL t4b_nvalid got %0d exp 2", nvalid); end
    nvec++; if (ovf !== 1'b0)       begin nerr++; $display("FAIL t4b_ovf got %b exp 0", ovf); end
    nvec++; if (hi_len !== 8'd5)    begin nerr++; $display("FAIL t4b_hi_len got %0d exp 5", hi_len); end
    nvec++; if (hi_units !== 4'd1)  begin nerr++; $display("FAIL t4b_hi_units got %0d exp 1", hi_units); end
    nvec++; if (lo_exact !== 1'b1)  begin nerr++; $display("FAIL t4b_lo_exact got %b exp 1", lo_exact); end
  endtask

  // en dropped for one cycle mid-low: period lost, lock lost, results held
  task automatic test_enable_drop();
    do_reset(1'b0);
    phase(1'b0, 2);
    phase(1'b1, 5);
    phase(1'b0, 5);
    step(1'b1);
    nvec++; if (locked !== 1'b1)   begin nerr++; $display("FAIL t5_locked1 got %b exp 1", locked); end
    phase(1'b1, 4);
    phase(1'b0, 3);
    en = 1'b0;
    step(1'b0);
    en = 1'b1;
    nvec++; if (locked !== 1'b0)   begin nerr++; $display("FAIL t5_unlock got %b exp 0", locked); end
    nvec++; if (valid !== 1'b0)    begin nerr++; $display("FAIL t5_valid_off got %b exp 0", valid); end
    nvec++; if (hi_len !== 8'd5)   begin nerr++; $display("FAIL t5_hold_hi got %0d exp 5", hi_len); end
    nvec++; if (lo_len !== 8'd5)   begin nerr++; $display("FAIL t5_hold_lo got %0d exp 5", lo_len); end
    phase(1'b0, 3);
    step(1'b1);
    nvec++; if (nvalid !== 1)      begin nerr++; $display("FAIL t5_aborted_valid got %0d exp 1", nvalid); end
    phase(1'b1, 2);
    phase(1'b0, 4);
    nvec++; if (locked !== 1'b0)   begin nerr++; $display("FAIL t5_still_unlocked got %b exp 0", locked); end
    step(1'b1);
    nvec++; if (nvalid !== 2)      begin nerr++; $display("FAIL t5_nvalid got %0d exp 2", nvalid); end
    nvec++; if (locked !== 1'b1)   begin nerr++; $display("FAIL t5_relock got %b exp 1", locked); end
    nvec++; if (hi_len !== 8'd3)   begin nerr++; $display("FAIL t5_hi_len got %0d exp 3", hi_len); end
    nvec++; if (lo_len !== 8'd4)   begin nerr++; $display("FAIL t5_lo_len got %0d exp 4", lo_len); end
  endtask

  // Alternating 1/0: every phase is a single cycle
  task automatic test_back_to_back();
    do_reset(1'b0);
    phase(1'b0, 2);
    step(1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0);
      step(1'b1);
    end
    nvec++; if (nvalid !== 6)      begin nerr++; $display("FAIL t6_nvalid got %0d exp 6", nvalid); end
    nvec++; if (gap_min !== 2)     begin nerr++; $display("FAIL t6_gap_min got %0d exp 2", gap_min); end
    nvec++; if (gap_max !== 2)     begin nerr++; $display("FAIL t6_gap_max got %0d exp 2", gap_max); end
    nvec++; if (hi_len !== 8'd1)   begin nerr++; $display("FAIL t6_hi_len got %0d exp 1", hi_len); end
    nvec++; if (lo_len !== 8'd1)   begin nerr++; $display("FAIL t6_lo_len got %0d exp 1", lo_len); end
    nvec++; if (hi_units !== 4'd0) begin nerr++; $display("FAIL t6_hi_units got %0d exp 0", hi_units); end
    nvec++; if (lo_units !== 4'd0) begin nerr++; $display("FAIL t6_lo_units got %0d exp 0", lo_units); end
    nvec++; if (hi_exact !== 1'b0) begin nerr++; $display("FAIL t6_hi_exact got %b exp 0", hi_exact); end
    nvec++; if (lo_exact !== 1'b0) begin nerr++; $display("FAIL t6_lo_exact got %b exp 0", lo_exact); end
    nvec++; if (ovf !== 1'b0)      begin nerr++; $display("FAIL t6_ovf got %b exp 0", ovf); end
  endtask

  initial begin
    nvec  = 0;
    nerr  = 0;
    cyc   = 0;
    rst   = 1'b1;
    en    = 1'b1;
    sq_in = 1'b0;
    clear_stats();
    test_reset();
    test_nominal();
    test_non_exact();
    test_reset_mid_phase();
    test_saturation();
    test_enable_drop();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
